// File: rtl/rr_decode_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_decode_arbiter_if
// Description : Bus between the requesting blocks and the round-robin
//               decode arbiter.
//               master : arbiter side. It receives req/done and drives the
//                        select, enable, grant and status lines.
//               slave  : requester side.
//   req[3:0]  requester -> arbiter   level request, bit i = requester i
//   done[3:0] requester -> arbiter   release pulse from requester i
//   s0, s1    arbiter -> decoder     owner index, registered
//   en        arbiter -> decoder     resource enable, high only while granted
//   gnt[3:0]  arbiter -> requester   one-hot grant = decode({s1,s0}) & en
//   busy      arbiter -> requester   granted or in the inter-owner gap
//   timeout   arbiter -> requester   one-cycle pulse on a forced release
// Revision    : 1.0  initial release
// ============================================================================
interface rr_decode_arbiter_if;
  logic [3:0] req;
  logic [3:0] done;
  logic       s0;
  logic       s1;
  logic       en;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  modport master (
    input  req, done,
    output s0, s1, en, gnt, busy, timeout
  );

  modport slave (
    output req, done,
    input  s0, s1, en, gnt, busy, timeout
  );
endinterface
`default_nettype wire

// File: rtl/rr_decode_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_decode_arbiter
// Description : Round-robin arbiter that shares one 2-to-4 decoded resource
//               among 4 requesters. It uses break-before-make handoff, with
//               one idle gap cycle between owners, and an optional hold
//               timeout that forces the current owner to release.
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               bus    rr_decode_arbiter_if.master (req/done in,
//                      s0/s1/en/gnt/busy/timeout out)
// Parameters  : MAX_HOLD  max grant length in cycles, 0 disables the timeout
//               CNT_W     hold-counter width, 2**CNT_W > MAX_HOLD
// Revision    : 1.0  initial release
// ============================================================================
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  rr_decode_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // The hold counter is 0 in the first grant cycle. The last allowed cycle
  // is therefore MAX_HOLD-1.
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sel,   w_sel_nxt;    // owner index, also drives s1/s0
  logic [1:0]       r_ptr,   w_ptr_nxt;    // highest-priority requester
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic [7:0]       w_req2;
  logic [3:0]       w_rot;
  logic [1:0]       w_off;
  logic [1:0]       w_win;
  logic             w_any;
  logic             w_own_rel;
  logic             w_hold_exp;

  // Rotate the requests so the bit at ptr lands in position 0. The lowest
  // set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    w_req2 = {bus.req, bus.req};
    w_rot  = w_req2[r_ptr +: 4];
    w_any  = |bus.req;
    w_off  = 2'd0;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else if (w_rot[3]) w_off = 2'd3;
    w_win = r_ptr + w_off;
  end

  // A voluntary release (done or dropped request) takes precedence over the
  // timeout. The timeout pulse is raised only when the counter alone forced
  // the release.
  always_comb begin
    w_own_rel  = bus.done[r_sel] | ~bus.req[r_sel];
    w_hold_exp = (MAX_HOLD != 0) && (r_cnt == c_HOLD_LAST);
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_win;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_own_rel || w_hold_exp) begin
          w_state_nxt   = ST_GAP;
          w_ptr_nxt     = r_sel + 2'd1;
          w_timeout_nxt = ~w_own_rel;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sel     <= 2'd0;
      r_ptr     <= 2'd0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // en and gnt are derived directly from the state register. An asynchronous
  // reset therefore clears them at once, with no clock edge needed.
  always_comb begin
    bus.s0      = r_sel[0];
    bus.s1      = r_sel[1];
    bus.en      = (r_state == ST_GRANT);
    bus.gnt     = bus.en ? (4'b0001 << r_sel) : 4'b0000;
    bus.busy    = (r_state == ST_GRANT) || (r_state == ST_GAP);
    bus.timeout = r_timeout;
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_decode_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_decode_arbiter
// Description : Scoreboard bench for rr_decode_arbiter. Directed scenarios
//               (reset, single grant, rotation, timeout, foreign done/drop,
//               asynchronous reset mid-grant) are followed by randomized
//               traffic. A cycle-level reference model pushes the expected
//               outputs for each clock edge. A monitor pops each entry and
//               compares it against the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rr_decode_arbiter;
  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  typedef struct packed {
    logic [1:0] sel;
    logic       en;
    logic [3:0] gnt;
    logic       busy;
    logic       tmo;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_decode_arbiter_if bus ();

  rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model. It tracks the owner, the number of cycles held so far
  // (1 in the first grant cycle) and the next starting priority.
  int m_owner = -1;
  int m_held  = 0;
  int m_prio  = 0;
  int m_sel   = 0;
  bit m_gap   = 0;
  bit m_tmo   = 0;

  always @(posedge clk) begin : p_model
    obs_t e;
    bit   let_go;
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_prio = 0; m_sel = 0; m_gap = 0; m_tmo = 0;
    end else begin
      m_tmo = 0;
      if (m_owner >= 0) begin
        let_go = bus.done[m_owner] || !bus.req[m_owner];
        if (let_go || (MAX_HOLD != 0 && m_held == MAX_HOLD)) begin
          m_tmo   = !let_go;
          m_prio  = (m_owner + 1) % 4;
          m_owner = -1;
          m_gap   = 1;
        end else begin
          m_held++;
        end
      end else begin
        m_gap = 0;
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && bus.req[(m_prio + k) % 4]) begin
            m_owner = (m_prio + k) % 4;
            m_sel   = m_owner;
            m_held  = 1;
          end
        end
      end
    end
    e.sel  = 2'(m_sel);
    e.en   = (m_owner >= 0);
    e.gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.busy = (m_owner >= 0) || m_gap;
    e.tmo  = m_tmo;
    exp_q.push_back(e);
  end

  logic [3:0] prev_gnt = 4'b0000;

  always @(posedge clk) begin : p_mon
    obs_t a;
    obs_t e;
    #1;
    a.sel  = {bus.s1, bus.s0};
    a.en   = bus.en;
    a.gnt  = bus.gnt;
    a.busy = bus.busy;
    a.tmo  = bus.timeout;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard t=%0t: DUT output present but no expected entry", $time);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle t=%0t: actual sel=%0d en=%b gnt=%b busy=%b timeout=%b, required sel=%0d en=%b gnt=%b busy=%b timeout=%b",
                 $time, a.sel, a.en, a.gnt, a.busy, a.tmo, e.sel, e.en, e.gnt, e.busy, e.tmo);
      end
    end
    n_cmp++;
    if (!$onehot0(a.gnt)) begin
      n_bad++;
      $display("FAIL onehot t=%0t: actual gnt=%b, required at most one bit set", $time, a.gnt);
    end
    if (prev_gnt != 4'b0000 && a.gnt != 4'b0000) begin
      n_cmp++;
      if (a.gnt !== prev_gnt) begin
        n_bad++;
        $display("FAIL handoff t=%0t: actual gnt=%b after %b, required a zero cycle between owners",
                 $time, a.gnt, prev_gnt);
      end
    end
    prev_gnt = a.gnt;
  end

  task automatic drive(input logic [3:0] r, input logic [3:0] d);
    @(negedge clk);
    bus.req  = r;
    bus.done = d;
  endtask

  logic [3:0] r_rand;
  logic [3:0] d_rand;

  initial begin
    // T1: reset held with every requester active
    bus.req  = 4'b1111;
    bus.done = 4'b0000;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // T3: rotation under full request, done pulsed every third cycle
    for (int k = 0; k < 16; k++) drive(4'b1111, (k % 3 == 2) ? 4'b1111 : 4'b0000);
    repeat (3) drive(4'b0000, 4'b0000);

    // T2: single requester, released by done
    repeat (3) drive(4'b0100, 4'b0000);
    drive(4'b0100, 4'b0100);
    repeat (3) drive(4'b0000, 4'b0000);

    // T4: held request with no done, which forces timeouts
    repeat (22) drive(4'b0010, 4'b0000);
    repeat (2) drive(4'b0000, 4'b0000);

    // T5: foreign done is ignored, then the owner drops its request
    repeat (2) drive(4'b1000, 4'b0000);
    drive(4'b1000, 4'b0001);
    repeat (2) drive(4'b1000, 4'b0000);
    repeat (3) drive(4'b0001, 4'b0000);
    repeat (2) drive(4'b0000, 4'b0000);

    // T6: asynchronous reset asserted mid-grant
    repeat (3) drive(4'b1000, 4'b0000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b0000 || bus.en !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: actual gnt=%b en=%b busy=%b, required gnt=0000 en=0 busy=0",
               bus.gnt, bus.en, bus.busy);
    end
    drive(4'b1001, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) drive(4'b1001, 4'b0000);
    repeat (2) drive(4'b0000, 4'b0000);

    // Randomized traffic: requests are sticky and done pulses are sparse
    r_rand = 4'b0000;
    for (int k = 0; k < 3000; k++) begin
      r_rand = r_rand ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      d_rand = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      drive(r_rand, d_rand);
    end
    repeat (4) drive(4'b0000, 4'b0000);
    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
